// File: rtl/la_clkgatectrl.sv
// Idle-driven clock-gate controller: produces the enable for a downstream
// NAND clock gate, shutting the clock after idle_cycles and waking on request.
module la_clkgatectrl #(
  parameter     PROP        = "DEFAULT",
  parameter int CW          = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          req,
  input  logic          force_on,
  input  logic [CW-1:0] idle_cycles,
  output logic          en_gate,
  output logic          ready,
  output logic          gated
);

  typedef enum logic [1:0] {
    ST_ON    = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OFF   = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] idle_last;
  logic          en_pre;
  logic          act;

  assign act       = req | force_on;
  // Live idle_cycles is used so a reduction mid-drain takes effect at once.
  assign idle_last = idle_cycles - CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ON: begin
        if (!act && (idle_cycles != '0)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (act || (idle_cycles == '0)) begin
          state_d = ST_ON;
        end else if (cnt_q >= idle_last) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_OFF: begin
        if (act) begin
          state_d = ST_WAKE;
          cnt_d   = '0;
        end
      end
      ST_WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_ON;
    endcase
  end

  // Posedge stage: state, counter and registered status outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_ON;
      cnt_q   <= '0;
      en_pre  <= 1'b1;
      ready   <= 1'b1;
      gated   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_pre  <= (state_d != ST_OFF);
      ready   <= (state_d == ST_ON) || (state_d == ST_DRAIN);
      gated   <= (state_d == ST_OFF);
    end
  end

  // Negedge stage: enable only moves while clk is low so the NAND cannot glitch
  always_ff @(negedge clk or negedge nreset) begin
    if (!nreset) begin
      en_gate <= 1'b1;
    end else begin
      en_gate <= en_pre;
    end
  end

endmodule
